ext_fifo_tx: RTL and testbench

Transmit-side bridge between fabric frame source and the GEM external TX FIFO interface. Buffers frame bytes, with SOP/EOP/error tags, in an internal circular FIFO. Signals the GEM only once a complete frame is stored (store-and-forward). Serves GEM read strobes with one-cycle latency and drains the remainder of a frame on GEM flush.

---
 rtl/ext_fifo_tx.sv | 148 ++++++++++++++
 tb/tb_ext_fifo_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ext_fifo_tx.sv
// Store-and-forward TX bridge from the fabric frame source to the GEM external TX FIFO port.
// Define EXT_FIFO_TX_CUTTHRU_EN to present a frame early once CUT_THRU bytes of it are buffered.
module ext_fifo_tx #(
  parameter int DEPTH    = 2048,
  parameter int CUT_THRU = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 i_data,
  input  logic                       i_wr,
  input  logic                       i_sop,
  input  logic                       i_eop,
  output logic                       o_full,
  output logic                       o_overflow,
  input  logic                       i_tx_rd,
  input  logic                       i_tx_flushed,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_valid,
  output logic                       o_tx_sop,
  output logic                       o_tx_eop,
  output logic                       o_tx_err,
  output logic                       o_tx_data_rdy,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef EXT_FIFO_TX_CUTTHRU_EN
  localparam bit CT_EN = 1'b1;
`else
  localparam bit CT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, READY, SEND, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [10:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, fcnt, frames_after;
  logic          open_frame, poison;
  logic          wr_ok, accept, drop, err_w;
  logic [10:0]   head;
  logic          head_eop, empty, pop, ct_start;

  assign wr_ok  = i_eop ? (level < LW'(DEPTH)) : (level < LW'(DEPTH - 1));
  assign accept = i_wr & wr_ok;
  assign drop   = i_wr & ~wr_ok;
  // A SOP arriving inside an open frame corrupts the new frame as well.
  assign err_w  = poison | (i_sop & open_frame);

  assign head     = mem[rd_ptr];
  assign head_eop = head[9];
  assign empty    = (level == '0);

  // Frames left once the head EOP leaves, counting an EOP written this same cycle.
  assign frames_after = fcnt + LW'(accept & i_eop) - LW'(1);
  assign ct_start     = CT_EN && (level >= LW'(CUT_THRU)) && open_frame && head[8];

  assign o_full        = (level >= LW'(DEPTH - 1));
  assign o_level       = level;
  assign o_tx_data_rdy = (state == READY) || (state == SEND);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if ((fcnt != '0) || ct_start) state_nxt = READY;
      end
      READY: begin
        if (i_tx_rd && !empty) begin
          pop = 1'b1;
          if (head_eop) state_nxt = (frames_after != '0) ? READY : IDLE;
          else          state_nxt = SEND;
        end
      end
      SEND: begin
        if (i_tx_rd && !empty) pop = 1'b1;
        if (pop && head_eop)   state_nxt = (frames_after != '0) ? READY : IDLE;
        else if (i_tx_flushed) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!empty) pop = 1'b1;
        if (pop && head_eop) state_nxt = (frames_after != '0) ? READY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {err_w, i_eop, i_sop, i_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      fcnt       <= '0;
      open_frame <= 1'b0;
      poison     <= 1'b0;
      o_overflow <= 1'b0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_tx_sop   <= 1'b0;
      o_tx_eop   <= 1'b0;
      o_tx_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      o_overflow <= drop;
      level      <= level + LW'(accept) - LW'(pop);
      fcnt       <= fcnt + LW'(accept & i_eop) - LW'(pop & head_eop);
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;

      if (accept) begin
        if (i_eop) begin
          open_frame <= 1'b0;
          poison     <= 1'b0;
        end else if (i_sop) begin
          open_frame <= 1'b1;
          poison     <= open_frame;
        end
      end else if (drop && !(i_sop && i_eop && !open_frame)) begin
        // A lost SOP still opens a frame, so its tail is marked corrupt.
        poison <= open_frame | i_sop;
        if (i_sop && !i_eop) open_frame <= 1'b1;
      end

      if (pop && (state != DRAIN)) begin
        o_tx_valid <= 1'b1;
        o_tx_data  <= head[7:0];
        o_tx_sop   <= head[8];
        o_tx_eop   <= head[9];
        o_tx_err   <= head[10];
      end else begin
        o_tx_valid <= 1'b0;
        o_tx_data  <= '0;
        o_tx_sop   <= 1'b0;
        o_tx_eop   <= 1'b0;
        o_tx_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ext_fifo_tx.sv
// Directed bench for ext_fifo_tx with DEPTH=64, CUT_THRU=8; checks depend on EXT_FIFO_TX_CUTTHRU_EN.
module tb_ext_fifo_tx;
  localparam int DEPTH = 64;
  localparam int CT    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_data;
  logic       i_wr, i_sop, i_eop, i_tx_rd, i_tx_flushed;
  logic       o_full, o_overflow, o_tx_valid, o_tx_sop, o_tx_eop, o_tx_err, o_tx_data_rdy;
  logic [7:0] o_tx_data;
  logic [6:0] o_level;

  int checks = 0;
  int failures = 0;

  ext_fifo_tx #(.DEPTH(DEPTH), .CUT_THRU(CT)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_wr(i_wr), .i_sop(i_sop), .i_eop(i_eop),
    .o_full(o_full), .o_overflow(o_overflow), .i_tx_rd(i_tx_rd), .i_tx_flushed(i_tx_flushed),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop),
    .o_tx_err(o_tx_err), .o_tx_data_rdy(o_tx_data_rdy), .o_level(o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic s, input logic e);
    i_data = d; i_sop = s; i_eop = e; i_wr = 1'b1;
    cyc();
    i_wr = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] d, input logic s, input logic e,
                        input logic er);
    i_tx_rd = 1'b1;
    cyc();
    i_tx_rd = 1'b0;
    chk({tag, "_valid"}, o_tx_valid, 1);
    chk({tag, "_data"}, o_tx_data, d);
    chk({tag, "_sop"}, o_tx_sop, s);
    chk({tag, "_eop"}, o_tx_eop, e);
    chk({tag, "_err"}, o_tx_err, er);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; i_data = '0; i_wr = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
    i_tx_rd = 1'b0; i_tx_flushed = 1'b0;
    #12;
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_rdy", o_tx_data_rdy, 0);
    chk("rst_level", o_level, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ovf", o_overflow, 0);
    rst = 1'b1;
    cyc();

    // 64-byte frame fills DEPTH exactly, EOP lands in the reserved slot
    for (int i = 0; i < 64; i++) begin
      wr(8'(i), i == 0, i == 63);
      if (i == 61) chk("full_at_62", o_full, 0);
      if (i == 62) chk("full_at_63", o_full, 1);
    end
    chk("t1_level", o_level, 64);
    chk("t1_rdy_early", o_tx_data_rdy, 0);
    cyc();
    chk("t1_rdy", o_tx_data_rdy, 1);
    for (int i = 0; i < 64; i++) rd_chk("t1_rd", 8'(i), i == 0, i == 63, 1'b0);
    chk("t1_rdy_after", o_tx_data_rdy, 0);
    chk("t1_level_after", o_level, 0);
    cyc();
    chk("t1_valid_idle", o_tx_valid, 0);

    // 68-byte frame: bytes 63..66 dropped, EOP stored with err
    for (int i = 0; i < 68; i++) begin
      wr(8'(i), i == 0, i == 67);
      chk("t2_ovf", o_overflow, (i >= 63 && i <= 66) ? 1 : 0);
    end
    chk("t2_level", o_level, 64);
    cyc();
    chk("t2_rdy", o_tx_data_rdy, 1);
    for (int i = 0; i < 63; i++) rd_chk("t2_rd", 8'(i), i == 0, 1'b0, 1'b0);
    rd_chk("t2_rd_eop", 8'd67, 1'b0, 1'b1, 1'b1);
    chk("t2_rdy_after", o_tx_data_rdy, 0);

    // two 3-byte frames back to back
    wr(8'hA0, 1, 0); wr(8'hA1, 0, 0); wr(8'hA2, 0, 1);
    wr(8'hB0, 1, 0); wr(8'hB1, 0, 0); wr(8'hB2, 0, 1);
    cyc();
    chk("t3_rdy", o_tx_data_rdy, 1);
    rd_chk("t3_a0", 8'hA0, 1, 0, 0);
    rd_chk("t3_a1", 8'hA1, 0, 0, 0);
    rd_chk("t3_a2", 8'hA2, 0, 1, 0);
    chk("t3_rdy_mid", o_tx_data_rdy, 1);
    chk("t3_level_mid", o_level, 3);
    rd_chk("t3_b0", 8'hB0, 1, 0, 0);
    rd_chk("t3_b1", 8'hB1, 0, 0, 0);
    rd_chk("t3_b2", 8'hB2, 0, 1, 0);
    chk("t3_rdy_end", o_tx_data_rdy, 0);
    chk("t3_level_end", o_level, 0);

    // partial read of 40-byte frame, then flush drains remaining 30
    for (int i = 0; i < 40; i++) wr(8'(i + 16), i == 0, i == 39);
    wr(8'hC0, 1, 0); wr(8'hC1, 0, 1);
    cyc();
    chk("t4_rdy", o_tx_data_rdy, 1);
    for (int i = 0; i < 10; i++) rd_chk("t4_rd", 8'(i + 16), i == 0, 1'b0, 1'b0);
    i_tx_flushed = 1'b1;
    cyc();
    i_tx_flushed = 1'b0;
    chk("t4_rdy_drain", o_tx_data_rdy, 0);
    chk("t4_level_drain", o_level, 32);
    for (int j = 0; j < 30; j++) begin
      i_tx_rd = (j % 3 == 0);
      cyc();
      chk("t4_drain_valid", o_tx_valid, 0);
      chk("t4_drain_sop", o_tx_sop, 0);
    end
    i_tx_rd = 1'b0;
    chk("t4_level_post", o_level, 2);
    chk("t4_rdy_post", o_tx_data_rdy, 1);
    rd_chk("t4_c0", 8'hC0, 1, 0, 0);
    rd_chk("t4_c1", 8'hC1, 0, 1, 0);
    chk("t4_rdy_end", o_tx_data_rdy, 0);

    // read with empty FIFO
    i_tx_rd = 1'b1;
    cyc();
    i_tx_rd = 1'b0;
    chk("t5_empty_valid", o_tx_valid, 0);
    chk("t5_empty_level", o_level, 0);

    // asynchronous reset in the middle of SEND
    wr(8'h50, 1, 0); wr(8'h51, 0, 0); wr(8'h52, 0, 0); wr(8'h53, 0, 1);
    cyc();
    rd_chk("t5_r0", 8'h50, 1, 0, 0);
    rd_chk("t5_r1", 8'h51, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_valid", o_tx_valid, 0);
    chk("t5_rst_data", o_tx_data, 0);
    chk("t5_rst_sop", o_tx_sop, 0);
    chk("t5_rst_rdy", o_tx_data_rdy, 0);
    chk("t5_rst_level", o_level, 0);
    #2 rst = 1'b1;
    cyc();
    wr(8'h77, 1, 1);
    cyc();
    chk("t5_post_rdy", o_tx_data_rdy, 1);
    chk("t5_post_level", o_level, 1);
    rd_chk("t5_post_rd", 8'h77, 1, 1, 0);
    chk("t5_post_rdy_end", o_tx_data_rdy, 0);

    // 8 bytes of an open frame: early rdy only with cut-through
    for (int i = 0; i < 8; i++) wr(8'(i + 8'h10), i == 0, 1'b0);
    cyc();
    cyc();
`ifdef EXT_FIFO_TX_CUTTHRU_EN
    chk("t6_ct_rdy", o_tx_data_rdy, 1);
    for (int i = 0; i < 8; i++) rd_chk("t6_ct_rd", 8'(i + 8'h10), i == 0, 1'b0, 1'b0);
    i_tx_rd = 1'b1;
    cyc();
    i_tx_rd = 1'b0;
    chk("t6_ct_underflow", o_tx_valid, 0);
    chk("t6_ct_level", o_level, 0);
    wr(8'h18, 0, 1);
    rd_chk("t6_ct_eop", 8'h18, 0, 1, 0);
    chk("t6_ct_rdy_end", o_tx_data_rdy, 0);
`else
    chk("t6_sf_rdy", o_tx_data_rdy, 0);
    wr(8'h18, 0, 1);
    cyc();
    chk("t6_sf_rdy_eop", o_tx_data_rdy, 1);
    for (int i = 0; i < 9; i++) rd_chk("t6_sf_rd", 8'(i + 8'h10), i == 0, i == 8, 1'b0);
    chk("t6_sf_rdy_end", o_tx_data_rdy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
